// File: rtl/riscv_single_cycle.sv
// Single-cycle RV32I subset core with internal 32x32 register file; optional MUL under `RISCV_MUL_EN`.
// Latency: decode/execute combinational, pc and register write commit on the rising clk edge.
// Backpressure: none; IMEM/DMEM are assumed to answer combinationally, one instruction retires per cycle.
module riscv_single_cycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] read_data,
    output logic [31:0] pc,
    output logic [31:0] alu_result,
    output logic [31:0] write_data,
    output logic        mem_write
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
    } alu_op_e;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_e;
    typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JAL, PC_JALR} pc_sel_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] registers [0:31];

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd_addr, rs1_addr, rs2_addr;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_a, alu_b, alu_out, pc_plus4, wb_value;
    alu_op_e     alu_op;
    wb_sel_e     wb_sel;
    pc_sel_e     pc_sel;
    logic        alu_a_pc, reg_write, mem_write_dec, branch_taken, rf_we;

    assign opcode   = instruction[6:0];
    assign rd_addr  = instruction[11:7];
    assign funct3   = instruction[14:12];
    assign rs1_addr = instruction[19:15];
    assign rs2_addr = instruction[24:20];
    assign funct7   = instruction[31:25];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'h000};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    assign rs1_val = (rs1_addr == 5'd0) ? 32'd0 : registers[rs1_addr];
    assign rs2_val = (rs2_addr == 5'd0) ? 32'd0 : registers[rs2_addr];

    // Anything not matched below falls through the defaults and behaves as a NOP.
    always_comb begin
        alu_op        = ALU_ADD;
        alu_a_pc      = 1'b0;
        alu_b         = rs2_val;
        reg_write     = 1'b0;
        mem_write_dec = 1'b0;
        wb_sel        = WB_ALU;
        pc_sel        = PC_SEQ;
        case (opcode)
            OPC_OP: begin
                reg_write = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: alu_op = ALU_ADD;
                    {7'b0100000, 3'b000}: alu_op = ALU_SUB;
                    {7'b0000000, 3'b001}: alu_op = ALU_SLL;
                    {7'b0000000, 3'b010}: alu_op = ALU_SLT;
                    {7'b0000000, 3'b011}: alu_op = ALU_SLTU;
                    {7'b0000000, 3'b100}: alu_op = ALU_XOR;
                    {7'b0000000, 3'b101}: alu_op = ALU_SRL;
                    {7'b0100000, 3'b101}: alu_op = ALU_SRA;
                    {7'b0000000, 3'b110}: alu_op = ALU_OR;
                    {7'b0000000, 3'b111}: alu_op = ALU_AND;
`ifdef RISCV_MUL_EN
                    {7'b0000001, 3'b000}: alu_op = ALU_MUL;
`endif
                    default:              reg_write = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                reg_write = 1'b1;
                alu_b     = imm_i;
                case (funct3)
                    3'b000: alu_op = ALU_ADD;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                    3'b001: begin
                        alu_op = ALU_SLL;
                        if (funct7 != 7'b0000000) reg_write = 1'b0;
                    end
                    default: begin
                        if (funct7 == 7'b0000000)      alu_op = ALU_SRL;
                        else if (funct7 == 7'b0100000) alu_op = ALU_SRA;
                        else                           reg_write = 1'b0;
                    end
                endcase
            end
            OPC_LOAD: begin
                alu_b = imm_i;
                if (funct3 == 3'b010) begin
                    reg_write = 1'b1;
                    wb_sel    = WB_MEM;
                end
            end
            OPC_STORE: begin
                alu_b         = imm_s;
                mem_write_dec = (funct3 == 3'b010);
            end
            OPC_BRANCH: pc_sel = PC_BRANCH;
            OPC_JAL: begin
                reg_write = 1'b1;
                wb_sel    = WB_PC4;
                pc_sel    = PC_JAL;
            end
            OPC_JALR: begin
                alu_b = imm_i;
                if (funct3 == 3'b000) begin
                    reg_write = 1'b1;
                    wb_sel    = WB_PC4;
                    pc_sel    = PC_JALR;
                end
            end
            OPC_LUI: begin
                reg_write = 1'b1;
                wb_sel    = WB_IMM;
            end
            OPC_AUIPC: begin
                reg_write = 1'b1;
                alu_a_pc  = 1'b1;
                alu_b     = imm_u;
            end
            default: ;
        endcase
    end

    assign alu_a = alu_a_pc ? pc_q : rs1_val;

    always_comb begin
        alu_out = 32'd0;
        case (alu_op)
            ALU_ADD:  alu_out = alu_a + alu_b;
            ALU_SUB:  alu_out = alu_a - alu_b;
            ALU_SLL:  alu_out = alu_a << alu_b[4:0];
            ALU_SLT:  alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_out = {31'd0, alu_a < alu_b};
            ALU_XOR:  alu_out = alu_a ^ alu_b;
            ALU_SRL:  alu_out = alu_a >> alu_b[4:0];
            ALU_SRA:  alu_out = $signed(alu_a) >>> alu_b[4:0];
            ALU_OR:   alu_out = alu_a | alu_b;
            ALU_AND:  alu_out = alu_a & alu_b;
`ifdef RISCV_MUL_EN
            ALU_MUL:  alu_out = alu_a * alu_b;
`endif
            default:  alu_out = 32'd0;
        endcase
    end

    // funct3 010/011 are not branches; they never take, so the NOP path applies.
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = (rs1_val == rs2_val);
            3'b001:  branch_taken = (rs1_val != rs2_val);
            3'b100:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  branch_taken = (rs1_val <  rs2_val);
            3'b111:  branch_taken = (rs1_val >= rs2_val);
            default: branch_taken = 1'b0;
        endcase
    end

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d = pc_plus4;
        case (pc_sel)
            PC_BRANCH: if (branch_taken) pc_d = pc_q + imm_b;
            PC_JAL:    pc_d = pc_q + imm_j;
            PC_JALR:   pc_d = {alu_out[31:1], 1'b0};
            default:   pc_d = pc_plus4;
        endcase
        case (wb_sel)
            WB_MEM:  wb_value = read_data;
            WB_PC4:  wb_value = pc_plus4;
            WB_IMM:  wb_value = imm_u;
            default: wb_value = alu_out;
        endcase
    end

    assign rf_we = reg_write && (rd_addr != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < 32; i++) registers[i] <= 32'd0;
        end else begin
            pc_q <= pc_d;
            if (rf_we) registers[rd_addr] <= wb_value;
        end
    end

    assign pc         = pc_q;
    assign alu_result = alu_out;
    assign write_data = rs2_val;
    assign mem_write  = mem_write_dec & reset;
endmodule

// File: tb/tb_riscv_single_cycle.sv
// Directed bench for riscv_single_cycle: ISA-level reference model plus literal checkpoints.
module tb_riscv_single_cycle;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] JR  = 7'b1100111;
    localparam logic [6:0] LU  = 7'b0110111;
    localparam logic [6:0] AUI = 7'b0010111;

    logic        clk, reset;
    logic [31:0] instruction, read_data;
    logic [31:0] pc, alu_result, write_data;
    logic        mem_write;

    riscv_single_cycle dut (
        .clk(clk), .reset(reset), .instruction(instruction), .read_data(read_data),
        .pc(pc), .alu_result(alu_result), .write_data(write_data), .mem_write(mem_write)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;
    logic        chk_en = 1'b0;
    logic [31:0] m_pc;
    logic [31:0] m_regs [0:31];
    logic [31:0] p_npc, p_val, p_addr, p_wd;
    logic [4:0]  p_rd;
    logic        p_we, p_mw, p_ls;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    endtask

    // Architectural interpretation of one instruction against the model state.
    task automatic predict(input logic [31:0] ins, input logic [31:0] rdat);
        logic [31:0] a, b, r, ui, t;
        int ii, is, ib, ij;
        logic [4:0] sh;
        logic ok, tk;
        a = m_regs[ins[19:15]];
        b = m_regs[ins[24:20]];
        ii = $signed(ins[31:20]);
        is = $signed({ins[31:25], ins[11:7]});
        ib = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        ij = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
        ui = ii;
        p_npc = m_pc + 4; p_we = 1'b0; p_rd = ins[11:7]; p_val = 32'h0;
        p_mw = 1'b0; p_ls = 1'b0; p_addr = 32'h0; p_wd = b;
        r = 32'h0; ok = 1'b1; tk = 1'b0;
        case (ins[6:0])
            7'b0110011: begin
                sh = b[4:0];
                case ({ins[31:25], ins[14:12]})
                    10'b0000000_000: r = a + b;
                    10'b0100000_000: r = a - b;
                    10'b0000000_001: r = a << sh;
                    10'b0000000_010: r = {31'h0, $signed(a) < $signed(b)};
                    10'b0000000_011: r = {31'h0, a < b};
                    10'b0000000_100: r = a ^ b;
                    10'b0000000_101: r = a >> sh;
                    10'b0100000_101: r = $signed(a) >>> sh;
                    10'b0000000_110: r = a | b;
                    10'b0000000_111: r = a & b;
`ifdef RISCV_MUL_EN
                    10'b0000001_000: r = a * b;
`endif
                    default: ok = 1'b0;
                endcase
                p_we = ok; p_val = r;
            end
            7'b0010011: begin
                sh = ins[24:20];
                case (ins[14:12])
                    3'b000: r = a + ui;
                    3'b010: r = {31'h0, $signed(a) < ii};
                    3'b011: r = {31'h0, a < ui};
                    3'b100: r = a ^ ui;
                    3'b110: r = a | ui;
                    3'b111: r = a & ui;
                    3'b001: begin ok = (ins[31:25] == 7'h00); r = a << sh; end
                    default: begin
                        if (ins[31:25] == 7'h00)      r = a >> sh;
                        else if (ins[31:25] == 7'h20) r = $signed(a) >>> sh;
                        else                          ok = 1'b0;
                    end
                endcase
                p_we = ok; p_val = r;
            end
            7'b0000011: if (ins[14:12] == 3'b010) begin
                p_ls = 1'b1; p_addr = a + ui; p_we = 1'b1; p_val = rdat;
            end
            7'b0100011: if (ins[14:12] == 3'b010) begin
                p_ls = 1'b1; p_addr = a + 32'(is); p_mw = 1'b1;
            end
            7'b1100011: begin
                case (ins[14:12])
                    3'b000: tk = (a == b);
                    3'b001: tk = (a != b);
                    3'b100: tk = ($signed(a) <  $signed(b));
                    3'b101: tk = ($signed(a) >= $signed(b));
                    3'b110: tk = (a <  b);
                    3'b111: tk = (a >= b);
                    default: tk = 1'b0;
                endcase
                if (tk) p_npc = m_pc + 32'(ib);
            end
            7'b1101111: begin p_we = 1'b1; p_val = m_pc + 4; p_npc = m_pc + 32'(ij); end
            7'b1100111: if (ins[14:12] == 3'b000) begin
                p_we = 1'b1; p_val = m_pc + 4; t = a + ui; p_npc = {t[31:1], 1'b0};
            end
            7'b0110111: begin p_we = 1'b1; p_val = {ins[31:12], 12'h0}; end
            7'b0010111: begin p_we = 1'b1; p_val = m_pc + {ins[31:12], 12'h0}; end
            default: ;
        endcase
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] rdat);
        instruction = ins;
        read_data   = rdat;
        predict(ins, rdat);
        #1;
        check("mem_write", {31'h0, mem_write}, {31'h0, p_mw});
        check("write_data", write_data, p_wd);
        if (p_ls) check("alu_result_addr", alu_result, p_addr);
    endtask

    task automatic clock_it();
        @(posedge clk);
        #1;
        if (p_we && p_rd != 5'd0) m_regs[p_rd] = p_val;
        m_pc = p_npc;
    endtask

    task automatic step(input logic [31:0] ins);
        issue(ins, 32'h0);
        clock_it();
    endtask

    // Compare process: architectural state against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            int bad;
            check("pc", pc, m_pc);
            bad = -1;
            for (int i = 0; i < 32; i++) if (dut.registers[i] !== m_regs[i]) bad = i;
            tests++;
            if (bad >= 0) begin
                fails++;
                $display("FAIL regfile x%0d: got %h expected %h", bad, dut.registers[bad], m_regs[bad]);
            end
        end
    end

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        logic [31:0] a, b, c, d, e;
        a = f7; b = rs2; c = rs1; d = f3; e = rd;
        return {a[6:0], b[4:0], c[4:0], d[2:0], e[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [6:0] op, input int rd, input int f3, input int rs1, input int imm);
        logic [31:0] v, d, f, s;
        v = imm; d = rd; f = f3; s = rs1;
        return {v[11:0], s[4:0], f[2:0], d[4:0], op};
    endfunction
    function automatic logic [31:0] enc_s(input int f3, input int rs1, input int rs2, input int imm);
        logic [31:0] v, f, s, t;
        v = imm; f = f3; s = rs1; t = rs2;
        return {v[11:5], t[4:0], s[4:0], f[2:0], v[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int imm);
        logic [31:0] v, f, s, t;
        v = imm; f = f3; s = rs1; t = rs2;
        return {v[12], v[10:5], t[4:0], s[4:0], f[2:0], v[4:1], v[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input int rd, input int imm);
        logic [31:0] v, d;
        v = imm; d = rd;
        return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_u(input logic [6:0] op, input int rd, input int imm);
        logic [31:0] v, d;
        v = imm; d = rd;
        return {v[19:0], d[4:0], op};
    endfunction

    initial begin
        logic [31:0] acc;
        reset = 1'b0; instruction = 32'h0; read_data = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", pc, 32'h0);
        acc = 32'h0;
        for (int i = 0; i < 32; i++) acc = acc | dut.registers[i];
        check("reset_regs", acc, 32'h0);
        check("reset_mem_write", {31'h0, mem_write}, 32'h0);
        reset = 1'b1;
        chk_en = 1'b1;

        step(32'h0); check("nop_pc0", pc, 32'd4);
        step(32'h0); check("nop_pc1", pc, 32'd8);
        step(32'h0); check("nop_pc2", pc, 32'd12);

        step(enc_i(OPI, 4, 0, 0, 32));
        step(enc_i(OPI, 5, 0, 0, 2));
        step(32'h40525333); check("sra_pos", dut.registers[6], 32'h8);
        step(enc_i(OPI, 4, 0, 0, -32));
        step(32'h40525333); check("sra_neg", dut.registers[6], 32'hFFFF_FFF8);
        step(enc_r(0, 5, 4, 5, 7)); check("srl_neg", dut.registers[7], 32'h3FFF_FFF8);

        step(enc_i(OPI, 1, 0, 0, -1));
        step(enc_i(OPI, 2, 0, 0, 1));
        step(enc_r(0, 2, 1, 0, 8));    check("add_wrap", dut.registers[8], 32'h0);
        step(enc_r(32, 2, 1, 0, 9));   check("sub", dut.registers[9], 32'hFFFF_FFFE);
        step(enc_r(0, 2, 1, 2, 10));   check("slt", dut.registers[10], 32'h1);
        step(enc_r(0, 2, 1, 3, 11));   check("sltu", dut.registers[11], 32'h0);
        step(enc_i(OPI, 0, 0, 1, 5));  check("x0_hardwired", dut.registers[0], 32'h0);
        step(enc_r(0, 2, 1, 4, 12));
        step(enc_r(0, 2, 1, 6, 17));
        step(enc_r(0, 2, 1, 7, 18));
        step(enc_r(0, 5, 2, 1, 19));
        step(enc_i(OPI, 13, 1, 2, 31)); check("slli31", dut.registers[13], 32'h8000_0000);
        step(enc_i(OPI, 14, 5, 13, 32'h404)); check("srai", dut.registers[14], 32'hF800_0000);
        step(enc_i(OPI, 24, 5, 13, 4));
        step(enc_i(OPI, 15, 2, 1, 0));
        step(enc_i(OPI, 25, 3, 2, -1)); check("sltiu_max", dut.registers[25], 32'h1);
        step(enc_i(OPI, 26, 4, 1, 32'h0F0));
        step(enc_i(OPI, 27, 6, 0, 32'h555));
        step(enc_i(OPI, 28, 7, 1, -16));
        step(enc_u(LU, 16, 32'h12345)); check("lui", dut.registers[16], 32'h1234_5000);
        step(enc_u(AUI, 29, 1));

        step(enc_i(OPI, 1, 0, 0, 32'h100));
        issue(enc_s(2, 1, 2, 8), 32'h0);
        check("sw_addr", alu_result, 32'h108);
        check("sw_data", write_data, 32'h1);
        check("sw_we", {31'h0, mem_write}, 32'h1);
        clock_it();
        issue(enc_i(LD, 3, 2, 1, 8), 32'hDEAD_BEEF);
        check("lw_we", {31'h0, mem_write}, 32'h0);
        clock_it();
        check("lw_data", dut.registers[3], 32'hDEAD_BEEF);
        issue(enc_s(0, 1, 2, 8), 32'h0);
        check("sb_unsupported", {31'h0, mem_write}, 32'h0);
        clock_it();

        step(enc_i(JR, 0, 0, 0, 8));   check("jalr_abs", pc, 32'd8);
        step(enc_b(0, 2, 2, 16));      check("beq_taken", pc, 32'd24);
        step(enc_j(1, 32));            check("jal_pc", pc, 32'd56);
        check("jal_link", dut.registers[1], 32'd28);
        step(enc_i(JR, 0, 0, 1, 0));   check("jalr_ret", pc, 32'd28);
        step(enc_b(1, 2, 2, 8));       check("bne_not_taken", pc, 32'd32);
        step(enc_b(4, 9, 2, 8));
        step(enc_b(6, 9, 2, 8));
        step(enc_b(5, 2, 9, 8));       check("bge_taken", pc, 32'd52);
        step(enc_b(7, 2, 9, 8));
        step(enc_b(0, 2, 9, 8));
        step(enc_b(1, 2, 9, -4));      check("bne_back", pc, 32'd56);
        step(enc_r(0, 2, 2, 0, 2));    check("rd_eq_rs", dut.registers[2], 32'd2);

        step(enc_i(OPI, 20, 0, 0, 7));
        step(enc_i(OPI, 21, 0, 0, -3));
        step(enc_r(1, 21, 20, 0, 22));
`ifdef RISCV_MUL_EN
        check("mul", dut.registers[22], 32'hFFFF_FFEB);
`else
        check("mul_nop", dut.registers[22], 32'h0);
`endif
        step(32'hFFFF_FFFF);
        step(enc_r(1, 2, 2, 5, 23));

        #2;
        instruction = enc_s(2, 1, 2, 8);
        reset = 1'b0;
        model_reset();
        #1;
        check("async_pc", pc, 32'h0);
        acc = 32'h0;
        for (int i = 0; i < 32; i++) acc = acc | dut.registers[i];
        check("async_regs", acc, 32'h0);
        check("async_mem_write", {31'h0, mem_write}, 32'h0);
        instruction = enc_i(OPI, 5, 0, 0, 99);
        @(posedge clk);
        #1;
        check("reset_discard", dut.registers[5], 32'h0);
        check("reset_hold_pc", pc, 32'h0);
        reset = 1'b1;
        step(32'h0); check("post_reset_pc", pc, 32'd4);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
